tick_generator: RTL and testbench

TICK_GENERATOR -- requirements
Module: tick_generator

---
 rtl/tick_pkg.sv | 14 +
 rtl/tick_generator_if.sv | 23 ++
 rtl/tick_generator_edge_detect.sv | 29 ++
 rtl/tick_generator.sv | 116 +++++++++++
 tb/tb_tick_generator.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_pkg.sv
// Shared types and defaults for the tick generator.
// State encoding and default bus/counter widths.
package tick_pkg;

    localparam int DEFAULT_DIV_W = 32;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } tick_state_t;

endpackage

// File: rtl/tick_generator_if.sv
// Tap bundle between the tick generator control and its edge detector.
// bus is the divided-clock bus, idx the tap index, en the tick gate.
interface tick_generator_if #(
    parameter int DIV_W = 32
);
    localparam int SEL_W = $clog2(DIV_W);

    logic [DIV_W-1:0] bus;
    logic [SEL_W-1:0] idx;
    logic             en;

    modport master (
        output bus,
        output idx,
        output en
    );

    modport slave (
        input bus,
        input idx,
        input en
    );
endinterface

// File: rtl/tick_generator_edge_detect.sv
// Samples the selected tap each cycle and flags a gated rising edge.
// bit_q runs in every state so it is fresh whenever the gate opens.
module edge_detect (
    input  logic             clock,
    input  logic             reset,
    tick_generator_if.slave  tap,
    output logic             rise
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = tap.bus[tap.idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    always_comb begin
        rise = tap.en && !bit_q && bit_d;
    end

endmodule

// File: rtl/tick_generator.sv
// One-cycle tick per rising edge of a selectable divided-clock tap.
// Define TICK_COUNT_EN to add count_clr / tick_count (wrapping counter).
module tick_generator
    import tick_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DIV_W-1:0]         divided_clocks,
    input  logic                     enable,
    input  logic [$clog2(DIV_W)-1:0] sel,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    output logic                     tick,
    output logic                     running
`ifdef TICK_COUNT_EN
    ,
    input  logic                     count_clr,
    output logic [CNT_W-1:0]         tick_count
`endif
);

    localparam int SEL_W = $clog2(DIV_W);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(DIV_W - 1);

    tick_state_t      state_q;
    tick_state_t      state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             tick_q;
    logic             tick_d;
    logic             load;
    logic             rise;

    tick_generator_if #(.DIV_W(DIV_W)) tap_if ();

    assign sel_ready = (state_q != ARM);
    assign running   = (state_q == RUN);
    assign tick      = tick_q;
    assign load      = sel_valid && sel_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = ARM;
            ARM:  state_d = enable ? RUN : IDLE;
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (load) begin
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        if (load) begin
            sel_d = (int'(sel) >= DIV_W) ? SEL_MAX : sel;
        end
    end

    // Gate on staying in RUN: leaving (disable or reload) must not emit a tick.
    assign tap_if.bus = divided_clocks;
    assign tap_if.idx = sel_q;
    assign tap_if.en  = (state_q == RUN) && (state_d == RUN);

    edge_detect u_edge (
        .clock (clock),
        .reset (reset),
        .tap   (tap_if.slave),
        .rise  (rise)
    );

    assign tick_d = rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

`ifdef TICK_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over a coincident tick.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(tick_d);
        if (count_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_count = cnt_q;
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Randomized and directed bench for tick_generator against a behavioural model.
// Build with TICK_COUNT_EN defined to also cover the tick counter.
module tb_tick_generator;

    localparam int DIV_W = 20;
    localparam int CNT_W = 4;
    localparam int SEL_W = $clog2(DIV_W);

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;

    logic clock = 1'b0;
    logic reset;
    logic sel_valid;
    logic clr;
    logic sel_ready;
    logic tick;
    logic running;
`ifdef TICK_COUNT_EN
    logic [CNT_W-1:0] tick_count;
`endif

    int checks = 0;
    int errors = 0;
    int bus_mode = 1;
    int n;

    tick_generator_if #(.DIV_W(DIV_W)) tb_if ();

    tick_generator #(
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .divided_clocks (tb_if.bus),
        .enable         (tb_if.en),
        .sel            (tb_if.idx),
        .sel_valid      (sel_valid),
        .sel_ready      (sel_ready),
        .tick           (tick),
        .running        (running)
`ifdef TICK_COUNT_EN
        ,
        .count_clr      (clr),
        .tick_count     (tick_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference model
    int m_mode = M_IDLE;
    int m_sel = 0;
    int m_cnt = 0;
    bit m_bit = 0;
    bit m_tick = 0;
    bit model_ok = 0;

    always @(posedge clock) begin
        int nxt;
        bit ld;
        bit b;
        if (reset) begin
            m_mode   = M_IDLE;
            m_sel    = 0;
            m_bit    = 0;
            m_tick   = 0;
            m_cnt    = 0;
            model_ok = 1;
        end else if (model_ok) begin
            ld = sel_valid && (m_mode != M_ARM);
            if (m_mode == M_IDLE) nxt = tb_if.en ? M_ARM : M_IDLE;
            else if (m_mode == M_ARM) nxt = tb_if.en ? M_RUN : M_IDLE;
            else nxt = !tb_if.en ? M_IDLE : (ld ? M_ARM : M_RUN);
            b = tb_if.bus[m_sel];
            m_tick = (m_mode == M_RUN) && (nxt == M_RUN) && b && !m_bit;
            m_bit = b;
            if (ld) m_sel = (int'(tb_if.idx) >= DIV_W) ? DIV_W - 1 : int'(tb_if.idx);
            m_cnt = clr ? 0 : (m_cnt + int'(m_tick)) % (1 << CNT_W);
            m_mode = nxt;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("tick", tick, m_tick);
            chk("running", running, m_mode == M_RUN);
            chk("sel_ready", sel_ready, m_mode != M_ARM);
`ifdef TICK_COUNT_EN
            chk("tick_count", tick_count, m_cnt);
`endif
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
        if (bus_mode == 1) tb_if.bus = tb_if.bus + 1'b1;
        else if (bus_mode == 2) tb_if.bus = DIV_W'($urandom);
    endtask

    task automatic wait_tick(input int budget, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!tick && cnt < budget);
        if (!tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic load(input int s);
        tb_if.idx = SEL_W'(s);
        sel_valid = 1'b1;
        cyc();
        sel_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sel_valid = 1'b0;
        clr = 1'b0;
        tb_if.en = 1'b0;
        tb_if.idx = '0;
        tb_if.bus = '0;
        repeat (3) cyc();
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", sel_ready, 1);
        chk("rst_sel_q", dut.sel_q, 0);
        reset = 1'b0;

        // sel=0 from IDLE, tick every 2 cycles
        tb_if.en = 1'b1;
        load(0);
        chk("arm_ready", sel_ready, 0);
        chk("arm_running", running, 0);
        cyc();
        chk("run_running", running, 1);
        wait_tick(16, n);
        repeat (2) begin
            wait_tick(16, n);
            chk("period_sel0", n, 2);
        end

        // reload sel=1 in RUN
        load(1);
        chk("reload_ready", sel_ready, 0);
        chk("reload_tick", tick, 0);
        chk("reload_running", running, 0);
        wait_tick(32, n);
        repeat (2) begin
            wait_tick(32, n);
            chk("period_sel1", n, 4);
        end

        // sel=3
        load(3);
        wait_tick(64, n);
        repeat (2) begin
            wait_tick(64, n);
            chk("period_sel3", n, 16);
        end

        // clamp
        load(31);
        chk("clamp_sel_q", dut.sel_q, DIV_W - 1);
        cyc();

        // enable dropped on a pending tap edge
        bus_mode = 0;
        tb_if.bus = '0;
        load(2);
        cyc();
        cyc();
        chk("drop_pre_running", running, 1);
        tb_if.bus = DIV_W'(4);
        tb_if.en = 1'b0;
        cyc();
        chk("drop_tick", tick, 0);
        chk("drop_running", running, 0);

        // reset in RUN on a tap rising
        tb_if.en = 1'b1;
        tb_if.bus = '0;
        load(3);
        cyc();
        cyc();
        chk("rrun_running", running, 1);
        tb_if.bus = DIV_W'(8);
        cyc();
        chk("rrun_ctrl_tick", tick, 1);
        tb_if.bus = '0;
        cyc();
        tb_if.bus = DIV_W'(8);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rrun_tick", tick, 0);
        chk("rrun_running", running, 0);
        chk("rrun_ready", sel_ready, 1);
        chk("rrun_sel_q", dut.sel_q, 0);

`ifdef TICK_COUNT_EN
        bus_mode = 1;
        load(0);
        cyc();
        clr = 1'b1;
        cyc();
        cyc();
        clr = 1'b0;
        chk("cnt_cleared", tick_count, 0);
        repeat (16) wait_tick(16, n);
        chk("cnt_wrap", tick_count, 0);
        wait_tick(16, n);
        chk("cnt_one", tick_count, 1);
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_tick", tick, 1);
        chk("clr_count", tick_count, 0);
`endif

        // randomized traffic
        bus_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tb_if.en = ($urandom_range(0, 9) != 0);
            sel_valid = ($urandom_range(0, 2) == 0);
            tb_if.idx = SEL_W'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        sel_valid = 1'b0;
        clr = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
